// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit MCU.
// Moore control decode from the state register plus the opcode/field latch captured in S_DECODE.
module control_unit #(
    parameter int ALU_OP_W   = 4,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            instruction,
    input  logic                  zero,
    input  logic                  carry,
    output logic                  reg_write,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [1:0]            mux1_sel,
    output logic                  load_a,
    output logic                  load_b,
    output logic                  load_c,
    output logic                  load_ir,
    output logic                  load_flags,
    output logic                  load_data_reg,
    output logic                  mem_write,
    output logic                  load_pc,
    output logic                  inc_pc,
    output logic                  pc_sel,
    output logic                  io_enable,
    output logic                  io_write_enable,
    output logic [REG_ADDR_W-1:0] read_addr1,
    output logic [REG_ADDR_W-1:0] read_addr2,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [7:0]            jump_address,
    output logic                  halted
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_JFETCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h8;
    localparam logic [3:0] OP_RSVD = 4'h9;
    localparam logic [3:0] OP_IN   = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_op_q;
    logic [1:0] r_ra_q;
    logic [1:0] r_rb_q;

    logic [3:0] w_op_live;
    logic       w_taken;

    assign w_op_live = instruction[7:4];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RESET;
            r_op_q  <= OP_NOP;
            r_ra_q  <= 2'b00;
            r_rb_q  <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_op_q <= instruction[7:4];
                r_ra_q <= instruction[3:2];
                r_rb_q <= instruction[1:0];
            end
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_op_q)
            OP_JMP:  w_taken = 1'b1;
            OP_JZ:   w_taken = zero;
            OP_JC:   w_taken = carry;
            default: w_taken = 1'b0;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        w_next_state    = r_state;
        reg_write       = 1'b0;
        alu_op          = '0;
        mux1_sel        = 2'b00;
        load_a          = 1'b0;
        load_b          = 1'b0;
        load_c          = 1'b0;
        load_ir         = 1'b0;
        load_flags      = 1'b0;
        load_data_reg   = 1'b0;
        mem_write       = 1'b0;
        load_pc         = 1'b0;
        inc_pc          = 1'b0;
        pc_sel          = 1'b0;
        io_enable       = 1'b0;
        io_write_enable = 1'b0;
        halted          = 1'b0;
        read_addr1      = REG_ADDR_W'(r_ra_q);
        read_addr2      = REG_ADDR_W'(r_rb_q);
        write_addr      = REG_ADDR_W'(r_ra_q);
        jump_address    = instruction;

        case (r_state)
            S_RESET: begin
                read_addr1   = '0;
                read_addr2   = '0;
                write_addr   = '0;
                jump_address = '0;
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                load_ir      = 1'b1;
                inc_pc       = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // The field latch is not loaded yet, so addresses come straight from the IR.
                read_addr1 = REG_ADDR_W'(instruction[3:2]);
                read_addr2 = REG_ADDR_W'(instruction[1:0]);
                write_addr = REG_ADDR_W'(instruction[3:2]);
                load_a     = 1'b1;
                load_b     = 1'b1;
                case (w_op_live)
                    OP_NOP, OP_RSVD: w_next_state = S_FETCH;
                    OP_LOAD:         w_next_state = S_MEM;
                    OP_IN:           w_next_state = S_WB;
                    OP_OUT: begin
                        io_enable       = 1'b1;
                        io_write_enable = 1'b1;
                        w_next_state    = S_FETCH;
                    end
                    OP_JMP, OP_JZ, OP_JC: w_next_state = S_JFETCH;
                    OP_HALT:              w_next_state = S_HALT;
                    default:              w_next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_op       = ALU_OP_W'({1'b0, r_op_q[2:0]});
                load_c       = 1'b1;
                load_flags   = 1'b1;
                w_next_state = S_WB;
            end
            S_MEM: begin
                load_data_reg = 1'b1;
                w_next_state  = S_WB;
            end
            S_WB: begin
                reg_write = 1'b1;
                if (r_op_q == OP_LOAD) begin
                    mux1_sel = 2'b01;
                end else if (r_op_q == OP_IN) begin
                    mux1_sel  = 2'b10;
                    io_enable = 1'b1;
                end
                w_next_state = S_FETCH;
            end
            S_JFETCH: begin
                load_ir      = 1'b1;
                inc_pc       = 1'b1;
                w_next_state = S_JUMP;
            end
            S_JUMP: begin
                pc_sel       = w_taken;
                load_pc      = w_taken;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                halted       = 1'b1;
                read_addr1   = '0;
                read_addr2   = '0;
                write_addr   = '0;
                jump_address = '0;
                w_next_state = S_HALT;
            end
            default: w_next_state = S_RESET;
        endcase
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit MCU.
- Consumes the instruction register contents and the registered flags from the datapath.
- Drives every datapath control, register-address and jump-address input.
- Sits beside the datapath in the top level; it is the only source of datapath control.

Parameters:
ALU_OP_W, 4, width of alu_op output
REG_ADDR_W, 3, width of register-file address outputs

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 forces state S_RESET immediately
instruction  input  8  instruction register output from datapath
zero  input  1  registered zero flag
carry  input  1  registered carry flag
reg_write  output  1  register-file write enable
alu_op  output  ALU_OP_W  ALU operation select
mux1_sel  output  2  write-back select: 00 reg C, 01 data register, 10 io_input
load_a  output  1  load reg A from read port 1
load_b  output  1  load reg B from read port 2
load_c  output  1  load reg C from ALU
load_ir  output  1  load instruction register
load_flags  output  1  load flags register
load_data_reg  output  1  load data register from RAM
mem_write  output  1  RAM write enable, tied 0 in this ISA revision
load_pc  output  1  load PC from pc_mux
inc_pc  output  1  PC increment
pc_sel  output  1  0 = PC+1, 1 = jump_address
io_enable  output  1  I/O block enable
io_write_enable  output  1  I/O output write
read_addr1  output  REG_ADDR_W  read port 1 address
read_addr2  output  REG_ADDR_W  read port 2 address
write_addr  output  REG_ADDR_W  register-file write address
jump_address  output  8  branch target
halted  output  1  high while in S_HALT

Behaviour:
Instruction format:
- op = instruction[7:4], ra = instruction[3:2], rb = instruction[1:0].
- Register addresses are zero-extended to REG_ADDR_W.

Opcodes:
- 0 NOP.
- 1–7 ALU: ra <- ra op rb, with alu_op = {0, op[2:0]}; flags are updated.
- 8 LOAD: data_reg <- RAM[rb], then ra <- data_reg.
- A IN: ra <- io_input.
- B OUT: io_output <- data_reg.
- C JMP, D JZ, E JC: two-byte instructions; the second byte is the target.
- F HALT.
- 9 is reserved and executes as NOP.

Output and latch rules:
- All outputs are Moore decodes of the state register plus a latched opcode/field register (op_q, ra_q, rb_q).
- op_q/ra_q/rb_q are captured from instruction in S_DECODE.
- Any output not listed for a state is 0.
- read_addr1 = ra_q, read_addr2 = rb_q, write_addr = ra_q in every state.
- jump_address = instruction in every state.

States (S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_JFETCH, S_JUMP, S_HALT):
- S_RESET: all outputs 0 → S_FETCH.
- S_FETCH: load_ir=1, inc_pc=1 → S_DECODE.
- S_DECODE: latch fields; load_a=1, load_b=1.
  - op 1–7 → S_EXEC.
  - op 8 → S_MEM.
  - op A → S_WB.
  - op B → S_FETCH, with io_enable=1 and io_write_enable=1 asserted in this state.
  - op C–E → S_JFETCH.
  - op F → S_HALT.
  - op 0/9 → S_FETCH.
  - Field decode for register addresses uses the live instruction in this state.
- S_EXEC: alu_op driven, load_c=1, load_flags=1 → S_WB.
- S_MEM: load_data_reg=1 → S_WB.
- S_WB: reg_write=1; mux1_sel is 00 for ALU, 01 for LOAD, 10 for IN (IN also asserts io_enable) → S_FETCH.
- S_JFETCH: load_ir=1, inc_pc=1 (IR now holds the target; PC points past it) → S_JUMP.
- S_JUMP: pc_sel=1; load_pc=1 when the branch is taken, otherwise all zero → S_FETCH.
  - JMP is always taken.
  - JZ is taken when zero=1.
  - JC is taken when carry=1.
  - Flags are sampled in this state, so they reflect the last S_EXEC.
- S_HALT: halted=1, all other outputs 0; remains until reset.

Cycle counts:
- ALU 4 cycles; LOAD 4; IN 3; OUT 2; NOP 2; jumps 4, taken or not.

Reset behaviour:
- Reset assertion mid-instruction aborts immediately.
- All outputs are 0 while reset=0, including halted.
- First S_FETCH occurs on the second rising edge after deassertion.

Invariants:
- Never assert load_pc and inc_pc together.
- Never assert reg_write and load_ir together.

Test Plan:
1. Release reset: cycle 0 all outputs 0; cycle 1 load_ir=1, inc_pc=1; halted=0.
2. instruction=0x16 (op 1, ra=1, rb=2): DECODE read_addr1=1, read_addr2=2, load_a=load_b=1; EXEC alu_op=1, load_c=load_flags=1; WB reg_write=1, write_addr=1, mux1_sel=00.
3. LOAD 0x83: S_MEM load_data_reg=1; WB mux1_sel=01, write_addr=0; then OUT 0xB0: DECODE io_enable=io_write_enable=1; total 6 cycles.
4. JZ 0xD0 then byte 0x40, with zero=1: S_JUMP jump_address=0x40, pc_sel=1, load_pc=1. Repeat with zero=0: load_pc=0, next state S_FETCH.
5. JC with carry=1, then HALT 0xF0: halted=1 held for 20 cycles, no load_ir.
6. Drive reset=0 asynchronously during S_EXEC: all outputs 0 before the next edge; after release, fetch restarts per scenario 1.
